// File: rtl/obuftds_bank_seq.sv
// N-lane registered differential tri-state output bank with a turnaround
// sequencer that drives an idle level before enabling and before releasing.
module obuftds_bank_seq #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TURN_CYC = 2,
  parameter logic        IDLE_VAL = 1'b0
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             CE,
  input  logic [WIDTH-1:0] I,
  input  logic             T,
  input  logic             GTS,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] OB,
  output logic             BUSY,
  output logic             DRV
);

  if (TURN_CYC > 15) begin : g_turn_range
    $error("obuftds_bank_seq: TURN_CYC must be in 0..15");
  end

  typedef enum logic [1:0] {
    HIZ   = 2'd0,
    PRE   = 2'd1,
    DRIVE = 2'd2,
    POST  = 2'd3
  } state_t;

  localparam logic [3:0]       CNT_INIT = (TURN_CYC == 0) ? 4'd0 : 4'(TURN_CYC - 1);
  localparam logic [WIDTH-1:0] IDLE_BUS = {WIDTH{IDLE_VAL}};

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] dreg;
  logic             oe;

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= HIZ;
      cnt   <= '0;
      dreg  <= IDLE_BUS;
    end else if (GTS) begin
      state <= HIZ;
      cnt   <= '0;
      dreg  <= IDLE_BUS;
    end else begin
      unique case (state)
        HIZ: begin
          if (!T) begin
            if (TURN_CYC == 0) begin
              state <= DRIVE;
            end else begin
              state <= PRE;
              cnt   <= CNT_INIT;
              dreg  <= IDLE_BUS;
            end
          end
        end
        PRE: begin
          if (T) begin
            state <= HIZ;
            cnt   <= '0;
          end else if (cnt == 4'd0) begin
            state <= DRIVE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DRIVE: begin
          if (CE) begin
            dreg <= I;
          end
          // Entering POST overrides the data load so the guard level wins.
          if (T) begin
            if (TURN_CYC == 0) begin
              state <= HIZ;
            end else begin
              state <= POST;
              cnt   <= CNT_INIT;
              dreg  <= IDLE_BUS;
            end
          end
        end
        POST: begin
          if (cnt == 4'd0) begin
            state <= HIZ;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= HIZ;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    oe   = (state != HIZ) && !GTS;
    BUSY = (state == PRE) || (state == POST);
    DRV  = (state == DRIVE) && !GTS;
  end

  assign O  = oe ? dreg  : {WIDTH{1'bz}};
  assign OB = oe ? ~dreg : {WIDTH{1'bz}};

endmodule
